// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared result codes and default widths for the 2-bit comparator
package cmp_pkg;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } cmp_res_t;

endpackage

// File: rtl/comparator_core.sv
// rtl/comparator_core.sv - combinational unsigned magnitude compare, MSB-first priority chain
module comparator_core #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             e,
  output logic             g,
  output logic             l
);

  logic [WIDTH-1:0] eq_bits;
  logic             eq_run;

  assign eq_bits = ~(a ^ b);
  assign e       = &eq_bits;

  // The first differing bit from the MSB down decides g versus l.
  always_comb begin
    eq_run = 1'b1;
    g      = 1'b0;
    l      = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      g      = g | (eq_run & a[i] & ~b[i]);
      l      = l | (eq_run & ~a[i] & b[i]);
      eq_run = eq_run & eq_bits[i];
    end
  end

endmodule

// File: rtl/comparator_2bit_df.sv
// rtl/comparator_2bit_df.sv - registered comparator with saturating per-outcome event counters
module comparator_2bit_df
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic             e,
  output logic             g,
  output logic             l,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt_eq,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt
);

  logic     e_c;
  logic     g_c;
  logic     l_c;
  cmp_res_t res;

  comparator_core #(.WIDTH(WIDTH)) u_core (
    .a (a),
    .b (b),
    .e (e_c),
    .g (g_c),
    .l (l_c)
  );

  assign res = e_c ? EQ : (g_c ? GT : LT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (!inc || (&v)) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e         <= 1'b0;
      g         <= 1'b0;
      l         <= 1'b0;
      out_valid <= 1'b0;
      cnt_eq    <= '0;
      cnt_gt    <= '0;
      cnt_lt    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        e <= e_c;
        g <= g_c;
        l <= l_c;
      end
      // Clear wins over a same-cycle increment; flags above still load.
      if (cnt_clr) begin
        cnt_eq <= '0;
        cnt_gt <= '0;
        cnt_lt <= '0;
      end else if (in_valid) begin
        cnt_eq <= sat_inc(cnt_eq, res == EQ);
        cnt_gt <= sat_inc(cnt_gt, res == GT);
        cnt_lt <= sat_inc(cnt_lt, res == LT);
      end
    end
  end

endmodule

// File: tb/tb_comparator_2bit_df.sv
// tb/tb_comparator_2bit_df.sv - self-checking bench: wide and narrow counter instances vs integer model
module tb_comparator_2bit_df;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] a = 2'd3;
  logic [1:0] b = 2'd0;
  logic       in_valid = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       e_w, g_w, l_w, ov_w;
  logic [7:0] ceq_w, cgt_w, clt_w;
  logic       e_n, g_n, l_n, ov_n;
  logic [1:0] ceq_n, cgt_n, clt_n;

  int checks = 0;
  int errors = 0;

  int m_e = 0, m_g = 0, m_l = 0, m_ov = 0;
  int m_eq = 0, m_gt = 0, m_lt = 0;

  always #5 clk = ~clk;

  comparator_2bit_df #(.WIDTH(2), .CNT_W(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .e(e_w), .g(g_w), .l(l_w), .out_valid(ov_w),
    .cnt_eq(ceq_w), .cnt_gt(cgt_w), .cnt_lt(clt_w)
  );

  comparator_2bit_df #(.WIDTH(2), .CNT_W(2)) dut_n (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .e(e_n), .g(g_n), .l(l_n), .out_valid(ov_n),
    .cnt_eq(ceq_n), .cnt_gt(cgt_n), .cnt_lt(clt_n)
  );

  function automatic int clamp(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("e_w", e_w, m_e);
    chk("g_w", g_w, m_g);
    chk("l_w", l_w, m_l);
    chk("ov_w", ov_w, m_ov);
    chk("cnt_eq_w", ceq_w, clamp(m_eq, 255));
    chk("cnt_gt_w", cgt_w, clamp(m_gt, 255));
    chk("cnt_lt_w", clt_w, clamp(m_lt, 255));
    chk("e_n", e_n, m_e);
    chk("g_n", g_n, m_g);
    chk("l_n", l_n, m_l);
    chk("ov_n", ov_n, m_ov);
    chk("cnt_eq_n", ceq_n, clamp(m_eq, 3));
    chk("cnt_gt_n", cgt_n, clamp(m_gt, 3));
    chk("cnt_lt_n", clt_n, clamp(m_lt, 3));
  endtask

  // Drive one cycle, advance the model over the edge, then check #1 after it.
  task automatic step(input int av, input int bv, input bit iv, input bit clr, input bit rstv);
    a        = 2'(av);
    b        = 2'(bv);
    in_valid = iv;
    cnt_clr  = clr;
    rst_n    = rstv;
    @(posedge clk);
    if (!rstv) begin
      m_e = 0; m_g = 0; m_l = 0; m_ov = 0;
      m_eq = 0; m_gt = 0; m_lt = 0;
    end else begin
      m_ov = iv;
      if (iv) begin
        m_e = (av == bv);
        m_g = (av > bv);
        m_l = (av < bv);
      end
      if (clr) begin
        m_eq = 0; m_gt = 0; m_lt = 0;
      end else if (iv) begin
        if (av == bv) m_eq++;
        else if (av > bv) m_gt++;
        else m_lt++;
      end
    end
    #1;
    check_all();
  endtask

  initial begin
    // Reset held with a live sample present.
    for (int i = 0; i < 3; i++) step(3, 0, 1'b1, 1'b0, 1'b0);
    step(3, 0, 1'b1, 1'b0, 1'b1);
    chk("post_reset_g", g_w, 1);
    chk("post_reset_ov", ov_w, 1);

    // Exhaustive sweep from cleared counters.
    step(0, 0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) step(k >> 2, k & 3, 1'b1, 1'b0, 1'b1);
    chk("sweep_cnt_eq", ceq_w, 4);
    chk("sweep_cnt_gt", cgt_w, 6);
    chk("sweep_cnt_lt", clt_w, 6);

    // Hold while idle.
    step(1, 2, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(3, 0, 1'b0, 1'b0, 1'b1);
    chk("hold_l", l_w, 1);

    // Saturation and clear priority on the narrow instance.
    step(0, 0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(i & 3, i & 3, 1'b1, 1'b0, 1'b1);
    chk("sat_cnt_eq_n", ceq_n, 3);
    step(2, 2, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt_eq_n", ceq_n, 0);
    chk("clr_e_n", e_n, 1);

    // Mid-stream reset.
    for (int i = 0; i < 6; i++) step((i % 2) ? 0 : 3, (i % 2) ? 2 : 1, 1'b1, 1'b0, 1'b1);
    step(3, 1, 1'b1, 1'b0, 1'b0);
    chk("midrst_ov", ov_w, 0);
    step(1, 3, 1'b1, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 60) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/comparator_2bit_df.md
# comparator_2bit_df

Registered magnitude comparator for two unsigned 2-bit operands. It produces mutually exclusive equal, greater-than and less-than flags one cycle after each valid sample. It also keeps saturating per-outcome event counters for debug and status readback. It sits in the datapath as a leaf compare stage feeding control logic that acts on the e/g/l flags.

## Interface
Parameters:
- WIDTH, 2, operand width in bits (unsigned)
- CNT_W, 8, width of each outcome event counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- in_valid  input  1  a/b are sampled this cycle
- cnt_clr  input  1  synchronous clear of all event counters
- e  output  1  registered, A == B
- g  output  1  registered, A > B
- l  output  1  registered, A < B
- out_valid  output  1  e/g/l updated this cycle
- cnt_eq  output  CNT_W  count of equal results
- cnt_gt  output  CNT_W  count of greater results
- cnt_lt  output  CNT_W  count of less results

## Operation
- Comparison is unsigned over WIDTH bits. The compare core is dataflow: equality is bitwise XNOR reduced by AND, and g/l come from an MSB-first priority chain.
- When in_valid=1 at a rising edge:
  - e/g/l load the compare result of that cycle's a/b.
  - Exactly one of e/g/l is 1.
  - out_valid goes to 1 for that following cycle.
- When in_valid=0:
  - e/g/l hold their last value.
  - out_valid is 0.
- Counters:
  - On each accepted sample, exactly one counter increments, matching the flag that is loaded.
  - Counters saturate at 2^CNT_W-1 with no wrap.
- Clear and simultaneous events:
  - cnt_clr=1 zeroes all three counters at the edge and takes priority over an increment in the same cycle.
  - e/g/l still update normally in that cycle.
- No back-pressure: every in_valid cycle is accepted.

## Timing
- Latency: 1 cycle from in_valid/a/b to e/g/l/out_valid. Throughput is 1 sample per cycle.
- Reset:
  - rst_n=0 at a rising edge forces e=0, g=0, l=0, out_valid=0 and all counters to 0.
  - Reset dominates in_valid and cnt_clr.
  - After reset, all three flags stay 0 until the first accepted sample.
  - Reset asserted mid-stream discards the in-flight sample; out_valid is 0 in the following cycle.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Structure
- Shared package cmp_pkg:
  - the result-code constants (EQ, GT, LT) as a 2-bit enum;
  - the default WIDTH and CNT_W.
- Sub-module comparator_core:
  - purely combinational, WIDTH-parameterized dataflow compare producing e/g/l;
  - the top-level block instantiates it once and adds the registers, valid pipeline and counters.
- Counters are one saturating-increment function applied to three registers.

## Test plan
- Exhaustive sweep with WIDTH=2, in_valid=1: apply all 16 {a,b} combinations in ascending order 0000..1111 (for example, {a,b}=0100 is a=1, b=0). One cycle later, check:
  - e=1 only for 00/00, 01/01, 10/10, 11/11;
  - g=1 for a>b (e.g. a=2, b=1);
  - l=1 for a<b (e.g. a=0, b=3).
  - At the end, cnt_eq=4, cnt_gt=6, cnt_lt=6.
- Reset behaviour:
  - Hold rst_n=0 with in_valid=1 and a=3, b=0: e/g/l/out_valid stay 0 and counters stay 0.
  - Release reset: the next edge gives g=1 and out_valid=1.
- Hold behaviour: sample a=1, b=2, giving l=1. Then drive in_valid=0 with a=3, b=0 for 3 cycles: l stays 1, out_valid=0, and counters are unchanged.
- Saturation and clear priority:
  - With CNT_W=2, apply 5 equal samples: cnt_eq=3.
  - Then apply cnt_clr=1 together with an equal sample: cnt_eq=0 and e=1.
- Mid-stream reset: stream alternating gt/lt samples, then assert rst_n=0 for 1 cycle. The next cycle shows out_valid=0, all flags 0 and counters 0.
